sa_rx_frame: RTL
================

Name: sa_rx_frame

Overview:
- Byte-level frame receiver feeding the station-bus RX path; sits directly upstream of sa_rx.
- Takes the deserialised byte stream from the line PHY and writes each frame into the 2 KB RX buffer RAM.
- Checks CRC-16 and signals rx_start, rx_done and rx_crc_rslt to the downstream frame parser.
- Locks the buffer until the parser releases it; drops overrun, short and long frames.

Parameters:
MAX_LEN, 2048, max stored bytes per frame including the 2 CRC bytes; must not exceed 2048 (11-bit address).
MIN_LEN, 4, min bytes per frame including CRC; shorter frames are discarded.
CRC_INIT, 16'hFFFF, CRC register preset at frame start.

Ports:
sys_clk  in  1  system clock, rising edge.
glbl_rst_n  in  1  asynchronous active-low reset.
rx_dv  in  1  frame gate from PHY; high for the whole frame.
rx_byte_valid  in  1  rx_byte valid this cycle; ignored while rx_dv=0.
rx_byte  in  8  received byte.
rx_buff_release  in  1  1-cycle pulse from parser: buffer consumed, unlock.
rx_buff_wren  out  1  RX buffer RAM write enable.
rx_buff_wraddr  out  11  RX buffer write address.
rx_buff_wrdata  out  8  RX buffer write data.
rx_start  out  1  1-cycle pulse: first byte of an accepted frame written.
rx_done  out  1  1-cycle pulse: frame complete and buffer locked.
rx_crc_rslt  out  1  1 = CRC good; valid from rx_done, held until next rx_start.
rx_len  out  11  stored byte count incl. CRC (0 encodes 2048); same validity as rx_crc_rslt.
rx_busy  out  1  high from rx_start until release, i.e. buffer not free.
rx_err  out  3  1-cycle pulses: [0] short, [1] long, [2] overrun.

Behaviour:
- Reset: all outputs 0. Internal CRC = CRC_INIT. Count = 0. State = SYNC.
- States: SYNC, IDLE, RECV, LOCK, DROP.
- SYNC: wait for rx_dv=0, then go to IDLE. This prevents capturing the tail of a frame that was in flight at reset.
- IDLE:
  - Byte accepted (rx_dv & rx_byte_valid) in cycle N: go to RECV.
  - Cycle N+1: rx_buff_wren=1, wraddr=0, wrdata=byte, rx_start=1, rx_busy=1, rx_crc_rslt and rx_len cleared.
  - rx_dv high with no valid byte: stay in IDLE.
- RECV:
  - Each accepted byte is written 1 cycle later at address = count; count then increments.
  - CRC update: CRC-16/CCITT, poly 0x1021, MSB first, non-reflected, over every byte including both CRC bytes. CRC bytes are transmitted high byte first.
- End of frame: rx_dv sampled 0 in cycle M.
  - count < MIN_LEN: rx_err[0] pulses at M+1, rx_busy drops, go to IDLE. No rx_done.
  - Otherwise at M+1: rx_done=1, rx_crc_rslt = (CRC residue == 16'h0000), rx_len = count, go to LOCK.
  - The last data write (byte accepted at M-1) lands at cycle M, always before rx_done.
- Overflow: a byte accepted when count == MAX_LEN is not written. rx_err[1] pulses next cycle, rx_busy drops, go to DROP.
- LOCK:
  - rx_busy=1, no writes.
  - rx_buff_release: rx_busy=0 next cycle, go to IDLE.
  - A byte accepted while still locked (no release this cycle): rx_err[2] pulses, go to DROP. The buffer stays locked; state returns to LOCK when that frame ends.
  - Release in the same cycle as a first byte: release wins, the byte is accepted as a new frame, and rx_start pulses next cycle.
- DROP: ignore bytes until rx_dv=0. Then go to IDLE, or back to LOCK if locked.
- rx_buff_release outside LOCK: ignored.
- Between bytes: rx_byte_valid may be low for any number of cycles while rx_dv=1; no timeout.
- Counter and address arithmetic: 12-bit count, address = count[10:0].
- Throughput: one byte per cycle sustained.

Test Plan:
- Good frame 0x31..0x39 then 0x29,0xB1 (CRC-16/CCITT of "123456789" = 0x29B1), back-to-back bytes → 11 writes at addr 0..10, rx_start 1 cycle after first byte, rx_done 1 cycle after rx_dv falls, rx_crc_rslt=1, rx_len=11.
- Same frame with the last byte 0xB0, plus gaps of 0–3 idle cycles between bytes → rx_done, rx_crc_rslt=0, rx_len=11, write addresses contiguous.
- 3-byte frame → 3 writes, rx_err[0] pulse, no rx_done, rx_busy low afterwards, next good frame accepted normally.
- 2049-byte frame → 2048 writes, rx_err[1] pulse at byte 2049, no rx_done, remainder ignored until rx_dv low.
- Second frame while LOCK without release → rx_err[2], no writes, rx_len/rx_crc_rslt unchanged. Then release together with the first byte of a third frame → third frame accepted with rx_start.
- Reset asserted mid-frame and released while rx_dv still high → no writes until rx_dv=0, next frame received correctly.

Source files
------------

// File: rtl/sa_rx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sa_rx_frame
// Purpose  : Byte-level frame receiver. Writes each received frame into the
//            2 KB RX buffer RAM, checks CRC-16/CCITT, and hands the locked
//            buffer to the downstream parser until it is released. Overrun,
//            short and long frames are dropped and flagged.
// Ports    : sys_clk, glbl_rst_n        clock / async active-low reset
//            rx_dv, rx_byte_valid,
//            rx_byte                    byte stream from the line PHY
//            rx_buff_release            parser has consumed the buffer
//            rx_buff_wren/wraddr/wrdata RX buffer RAM write port
//            rx_start, rx_done          frame start / complete pulses
//            rx_crc_rslt, rx_len        frame result, held until next start
//            rx_busy                    buffer in use (start .. release)
//            rx_err[2:0]                pulses: overrun, long, short
// Revision : 1.0 - initial release
// ============================================================================
module sa_rx_frame #(
  parameter int unsigned MAX_LEN  = 2048,
  parameter int unsigned MIN_LEN  = 4,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        sys_clk,
  input  logic        glbl_rst_n,
  input  logic        rx_dv,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_buff_release,
  output logic        rx_buff_wren,
  output logic [10:0] rx_buff_wraddr,
  output logic [7:0]  rx_buff_wrdata,
  output logic        rx_start,
  output logic        rx_done,
  output logic        rx_crc_rslt,
  output logic [10:0] rx_len,
  output logic        rx_busy,
  output logic [2:0]  rx_err
);

  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RECV = 3'd2;
  localparam logic [2:0] S_LOCK = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  localparam logic [11:0] c_MAX_LEN = 12'(MAX_LEN);
  localparam logic [11:0] c_MIN_LEN = 12'(MIN_LEN);

  // CRC-16/CCITT, poly 0x1021, MSB first, non-reflected.
  function automatic logic [15:0] f_crc_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] crc;
    crc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc[15] ^ data[i]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
      else                   crc = {crc[14:0], 1'b0};
    end
    return crc;
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [11:0] r_count;
  logic [15:0] r_crc;
  logic        r_wren;
  logic [10:0] r_wraddr;
  logic [7:0]  r_wrdata;
  logic        r_start;
  logic        r_done;
  logic        r_crc_rslt;
  logic [10:0] r_len;
  logic        r_busy;
  logic [2:0]  r_err;

  logic        w_acc;
  logic        w_new_frame;
  logic        w_store;
  logic        w_ovf;
  logic        w_eof;
  logic        w_short;
  logic        w_good;
  logic        w_lock_ovr;
  logic        w_unlock;

  logic [11:0] w_count_nxt;
  logic [15:0] w_crc_nxt;
  logic [10:0] w_len_nxt;
  logic        w_rslt_nxt;
  logic        w_busy_nxt;

  assign w_acc = rx_dv & rx_byte_valid;

  // A release arriving with the first byte of a new frame unlocks and
  // starts that frame in the same cycle.
  assign w_new_frame = w_acc & ((r_state == S_IDLE) |
                                ((r_state == S_LOCK) & rx_buff_release));
  assign w_store     = w_acc & (r_state == S_RECV) & (r_count != c_MAX_LEN);
  assign w_ovf       = w_acc & (r_state == S_RECV) & (r_count == c_MAX_LEN);
  assign w_eof       = (r_state == S_RECV) & ~rx_dv;
  assign w_short     = w_eof & (r_count < c_MIN_LEN);
  assign w_good      = w_eof & ~w_short;
  assign w_lock_ovr  = w_acc & (r_state == S_LOCK) & ~rx_buff_release;
  assign w_unlock    = (r_state == S_LOCK) & rx_buff_release & ~w_acc;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) r_state <= S_SYNC;
    else             r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC: if (!rx_dv) w_state_nxt = S_IDLE;
      S_IDLE: if (w_acc)  w_state_nxt = S_RECV;
      S_RECV: begin
        if (!rx_dv)     w_state_nxt = w_short ? S_IDLE : S_LOCK;
        else if (w_ovf) w_state_nxt = S_DROP;
      end
      S_LOCK: begin
        if (rx_buff_release) w_state_nxt = w_acc ? S_RECV : S_IDLE;
        else if (w_acc)      w_state_nxt = S_DROP;
      end
      // r_busy is still set when the dropped frame was an overrun of a
      // locked buffer, so it tells us where to return.
      S_DROP: if (!rx_dv) w_state_nxt = r_busy ? S_LOCK : S_IDLE;
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_nxt = r_count;
    w_crc_nxt   = r_crc;
    w_len_nxt   = r_len;
    w_rslt_nxt  = r_crc_rslt;
    w_busy_nxt  = r_busy;

    if (w_new_frame) begin
      w_count_nxt = 12'd1;
      w_crc_nxt   = f_crc_byte(CRC_INIT, rx_byte);
      w_len_nxt   = 11'd0;
      w_rslt_nxt  = 1'b0;
      w_busy_nxt  = 1'b1;
    end else if (w_store) begin
      w_count_nxt = r_count + 12'd1;
      w_crc_nxt   = f_crc_byte(r_crc, rx_byte);
    end

    // Running over the CRC bytes too leaves a zero residue on a good frame.
    if (w_good) begin
      w_len_nxt  = r_count[10:0];
      w_rslt_nxt = (r_crc == 16'h0000);
    end

    if (w_short || w_ovf || w_unlock) w_busy_nxt = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      r_count    <= 12'd0;
      r_crc      <= CRC_INIT;
      r_wren     <= 1'b0;
      r_wraddr   <= 11'd0;
      r_wrdata   <= 8'd0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_crc_rslt <= 1'b0;
      r_len      <= 11'd0;
      r_busy     <= 1'b0;
      r_err      <= 3'd0;
    end else begin
      r_count    <= w_count_nxt;
      r_crc      <= w_crc_nxt;
      r_wren     <= w_new_frame | w_store;
      if (w_new_frame || w_store) begin
        r_wraddr <= w_new_frame ? 11'd0 : r_count[10:0];
        r_wrdata <= rx_byte;
      end
      r_start    <= w_new_frame;
      r_done     <= w_good;
      r_crc_rslt <= w_rslt_nxt;
      r_len      <= w_len_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= {w_lock_ovr, w_ovf, w_short};
    end
  end

  assign rx_buff_wren   = r_wren;
  assign rx_buff_wraddr = r_wraddr;
  assign rx_buff_wrdata = r_wrdata;
  assign rx_start       = r_start;
  assign rx_done        = r_done;
  assign rx_crc_rslt    = r_crc_rslt;
  assign rx_len         = r_len;
  assign rx_busy        = r_busy;
  assign rx_err         = r_err;

endmodule
`default_nettype wire
